dds_multi_core: RTL and testbench



---
 rtl/dds_pkg.sv | 31 +++
 rtl/dds_sine_rom.sv | 56 +++++
 rtl/dds_multi_core.sv | 200 ++++++++++++++++++++
 tb/tb_dds_multi_core.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// dds_pkg -- shared types and constants for the multi-channel DDS engine.
//   shape_t    : waveform selector stored per channel
//   REG_*      : register-port address map
//   AMP_UNITY  : amplitude code giving unity gain (and the saturation ceiling)
//   LFSR_*     : seed and tap mask of the optional dither generator
//   amp_sat()  : clamps an amplitude code to unity
package dds_pkg;

  typedef enum logic [1:0] {
    SH_SINE   = 2'd0,
    SH_SQUARE = 2'd1,
    SH_TRI    = 2'd2,
    SH_SAW    = 2'd3
  } shape_t;

  localparam logic [1:0] REG_FTW   = 2'd0;
  localparam logic [1:0] REG_POFS  = 2'd1;
  localparam logic [1:0] REG_SHAPE = 2'd2;
  localparam logic [1:0] REG_AMP   = 2'd3;

  localparam logic [8:0] AMP_UNITY = 9'd256;

  // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [8:0] amp_sat(input logic [8:0] amp);
    return (amp > AMP_UNITY) ? AMP_UNITY : amp;
  endfunction

endpackage

// File: rtl/dds_sine_rom.sv
// dds_sine_rom -- registered quarter-wave sine table with full-period folding.
//   clk, rst : clock, asynchronous active-high reset
//   en       : read enable (pipeline advance)
//   addr     : full-period phase index, LUT_AW bits
//   data     : signed sample, amplitude 2^(DAC_W-1)-1, one cycle after addr
// Entries are sampled at half-step offsets so the mirrored quadrants reuse
// the table exactly and the phase-zero entry rounds to zero.
module dds_sine_rom #(
  parameter int DAC_W  = 8,
  parameter int LUT_AW = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [LUT_AW-1:0]        addr,
  output logic signed [DAC_W-1:0]  data
);

  localparam int QN = 32'd1 << (LUT_AW - 2);

  function automatic logic [DAC_W-2:0] quarter_entry(input int i);
    real ang;
    real mag;
    ang = 1.5707963267948966 * (real'(i) + 0.5) / real'(QN);
    mag = real'((32'd1 << (DAC_W - 1)) - 32'd1) * $sin(ang);
    return (DAC_W-1)'($rtoi(mag + 0.5));
  endfunction

  logic [DAC_W-2:0] quarter [QN];

  for (genvar g = 0; g < QN; g++) begin : g_tab
    localparam logic [DAC_W-2:0] ENTRY = quarter_entry(g);
    assign quarter[g] = ENTRY;
  end

  logic [1:0]              quad;
  logic [LUT_AW-3:0]       idx;
  logic [LUT_AW-3:0]       midx;
  logic signed [DAC_W-1:0] pos;

  assign quad = addr[LUT_AW-1:LUT_AW-2];
  assign idx  = addr[LUT_AW-3:0];
  // Odd quadrants run the table backwards.
  assign midx = quad[0] ? ~idx : idx;
  assign pos  = signed'({1'b0, quarter[midx]});

  // Registered read; the lower half period is the negated upper half.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= {DAC_W{1'b0}};
    end else if (en) begin
      data <= quad[1] ? -pos : pos;
    end
  end

endmodule

// File: rtl/dds_multi_core.sv
// dds_multi_core -- NCH-channel DDS with shadowed parameters and atomic commit.
//   iclk, irst       : clock, asynchronous active-high reset
//   isample_en       : advance every accumulator and the 3-stage pipeline
//   iwr_valid/owr_ready, iwr_ch, iwr_addr, iwr_data : shadow register writes
//   iupdate          : copy all shadow registers to the active set
//   odac             : unsigned codes, channel k at [k*DAC_W +: DAC_W]
//   ovalid           : odac was refreshed this cycle
//   owrap            : per-channel accumulator carry for the sample on odac
// Optional feature: define DDS_DITHER_EN to add LFSR dither to sine addressing.
module dds_multi_core #(
  parameter int NCH    = 2,
  parameter int ACC_W  = 32,
  parameter int DAC_W  = 8,
  parameter int LUT_AW = 10,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 iclk,
  input  logic                 irst,
  input  logic                 isample_en,
  input  logic                 iwr_valid,
  output logic                 owr_ready,
  input  logic [CH_W-1:0]      iwr_ch,
  input  logic [1:0]           iwr_addr,
  input  logic [ACC_W-1:0]     iwr_data,
  input  logic                 iupdate,
  output logic [NCH*DAC_W-1:0] odac,
  output logic                 ovalid,
  output logic [NCH-1:0]       owrap
);

  import dds_pkg::*;

  localparam logic [DAC_W-1:0] MID = {1'b1, {(DAC_W-1){1'b0}}};
  localparam logic [DAC_W-1:0] POS_FULL = {1'b0, {(DAC_W-1){1'b1}}};

  // A commit cycle refuses writes so shadow and active copies never race.
  logic wr_take;
  assign owr_ready = ~iupdate;
  assign wr_take   = iwr_valid & ~iupdate;

  logic v1;
  logic v2;

  // Fill tracking: ovalid only once three enabled steps have passed.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      ovalid <= 1'b0;
    end else begin
      ovalid <= isample_en & v2;
      if (isample_en) begin
        v1 <= 1'b1;
        v2 <= v1;
      end
    end
  end

  logic [ACC_W-1:0] dith;

`ifdef DDS_DITHER_EN
  localparam int DITH_W = ((ACC_W - LUT_AW) > 16) ? 16 : (ACC_W - LUT_AW);
  localparam logic [15:0] DITH_MASK = 16'((32'd1 << DITH_W) - 32'd1);

  logic [15:0] lfsr;

  // Fibonacci LFSR stepped with the sample clock enable.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      lfsr <= LFSR_SEED;
    end else if (isample_en) begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign dith = ACC_W'(lfsr & DITH_MASK);
`else
  assign dith = {ACC_W{1'b0}};
`endif

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [ACC_W-1:0]        ftw_sh, pofs_sh, ftw_a, pofs_a;
    shape_t                  shape_sh, shape_a, shape1, shape2;
    logic [8:0]              amp_sh, amp_a, amp1, amp2;
    logic [ACC_W-1:0]        acc, pofs1, p;
    logic                    wrap1, wrap2, wrap3;
    logic [DAC_W:0]          ph2;
    logic signed [DAC_W-1:0] sine_w, w;
    logic [DAC_W-1:0]        fold, odac_r;
    logic signed [DAC_W+9:0] prod;
    logic                    sel;

    assign sel = wr_take && (iwr_ch == CH_W'(k));

    // Shadow register file written through the handshake port.
    always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
        ftw_sh   <= {ACC_W{1'b0}};
        pofs_sh  <= {ACC_W{1'b0}};
        shape_sh <= SH_SINE;
        amp_sh   <= AMP_UNITY;
      end else if (sel) begin
        case (iwr_addr)
          REG_FTW:   ftw_sh   <= iwr_data;
          REG_POFS:  pofs_sh  <= iwr_data;
          REG_SHAPE: shape_sh <= shape_t'(iwr_data[1:0]);
          REG_AMP:   amp_sh   <= iwr_data[8:0];
          default:   ftw_sh   <= ftw_sh;
        endcase
      end
    end

    // Active registers, loaded from the shadows on a commit.
    always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
        ftw_a   <= {ACC_W{1'b0}};
        pofs_a  <= {ACC_W{1'b0}};
        shape_a <= SH_SINE;
        amp_a   <= AMP_UNITY;
      end else if (iupdate) begin
        ftw_a   <= ftw_sh;
        pofs_a  <= pofs_sh;
        shape_a <= shape_sh;
        amp_a   <= amp_sh;
      end
    end

    // S1: accumulator step; per-sample parameters travel with the phase so
    // a commit never changes a sample already in flight.
    always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
        acc    <= {ACC_W{1'b0}};
        wrap1  <= 1'b0;
        pofs1  <= {ACC_W{1'b0}};
        shape1 <= SH_SINE;
        amp1   <= AMP_UNITY;
      end else if (isample_en) begin
        {wrap1, acc} <= {1'b0, acc} + {1'b0, ftw_a};
        pofs1  <= pofs_a;
        shape1 <= shape_a;
        amp1   <= amp_sat(amp_a);
      end
    end

    assign p = acc + pofs1;

    dds_sine_rom #(.DAC_W(DAC_W), .LUT_AW(LUT_AW)) u_rom (
      .clk  (iclk),
      .rst  (irst),
      .en   (isample_en),
      .addr (LUT_AW'((p + dith) >> (ACC_W - LUT_AW))),
      .data (sine_w)
    );

    // S2: phase MSBs for the non-sine shapes, alongside the ROM read.
    always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
        ph2    <= {(DAC_W+1){1'b0}};
        shape2 <= SH_SINE;
        amp2   <= AMP_UNITY;
        wrap2  <= 1'b0;
      end else if (isample_en) begin
        ph2    <= (DAC_W+1)'(p >> (ACC_W - DAC_W - 1));
        shape2 <= shape1;
        amp2   <= amp1;
        wrap2  <= wrap1;
      end
    end

    // S3 waveform select; the triangle folds the top DAC_W+1 phase bits.
    always_comb begin
      w    = {DAC_W{1'b0}};
      fold = ph2[DAC_W] ? ~ph2[DAC_W-1:0] : ph2[DAC_W-1:0];
      case (shape2)
        SH_SINE:   w = sine_w;
        SH_SQUARE: w = ph2[DAC_W] ? MID : POS_FULL;
        SH_TRI:    w = {~fold[DAC_W-1], fold[DAC_W-2:0]};
        SH_SAW:    w = {~ph2[DAC_W], ph2[DAC_W-1:1]};
        default:   w = {DAC_W{1'b0}};
      endcase
    end

    assign prod = (DAC_W+10)'(w) * (DAC_W+10)'($signed({1'b0, amp2}));

    // S3: scale, shift to offset-binary and register the output.
    always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
        odac_r <= MID;
        wrap3  <= 1'b0;
      end else if (isample_en) begin
        odac_r <= DAC_W'(prod >>> 8) ^ MID;
        wrap3  <= wrap2;
      end
    end

    assign odac[k*DAC_W +: DAC_W] = odac_r;
    assign owrap[k]               = wrap3;
  end

endmodule

// File: tb/tb_dds_multi_core.sv
// tb_dds_multi_core -- randomized and directed check of dds_multi_core
// against a sample-level reference model (default parameters).
module tb_dds_multi_core;

  localparam int NCH = 2;
  localparam real PI = 3.14159265358979323846;

  logic        iclk = 1'b0;
  logic        irst;
  logic        isample_en;
  logic        iwr_valid;
  logic        owr_ready;
  logic [0:0]  iwr_ch;
  logic [1:0]  iwr_addr;
  logic [31:0] iwr_data;
  logic        iupdate;
  logic [15:0] odac;
  logic        ovalid;
  logic [1:0]  owrap;

  always #5 iclk = ~iclk;

  dds_multi_core dut (
    .iclk       (iclk),
    .irst       (irst),
    .isample_en (isample_en),
    .iwr_valid  (iwr_valid),
    .owr_ready  (owr_ready),
    .iwr_ch     (iwr_ch),
    .iwr_addr   (iwr_addr),
    .iwr_data   (iwr_data),
    .iupdate    (iupdate),
    .odac       (odac),
    .ovalid     (ovalid),
    .owrap      (owrap)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] m_ftw_sh[NCH], m_pofs_sh[NCH], m_ftw[NCH], m_pofs[NCH], m_acc[NCH];
  int          m_shape_sh[NCH], m_shape[NCH], m_amp_sh[NCH], m_amp[NCH];

  typedef struct {
    logic [15:0] code;
    logic [1:0]  wrap;
  } samp_t;

  samp_t       pipe[$];
  logic [15:0] e_odac;
  logic        e_valid;
  logic [1:0]  e_wrap;

  function automatic int sine_val(input logic [31:0] p);
    int  a;
    real x;
    a = int'(p >> 22);
    x = 127.0 * $sin(2.0 * PI * (real'(a) + 0.5) / 1024.0);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  function automatic logic [7:0] code_of(input logic [31:0] p, input int shape, input int amp);
    int w, a, s, t, f;
    case (shape)
      0: w = sine_val(p);
      1: w = p[31] ? -128 : 127;
      2: begin
        t = int'(p >> 23);
        f = (t < 256) ? t : 511 - t;
        w = f - 128;
      end
      3: w = int'(p >> 24) - 128;
      default: w = 0;
    endcase
    a = (amp > 256) ? 256 : amp;
    s = (w * a) >>> 8;
    return 8'(s + 128);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_ftw_sh[c] = 32'd0; m_pofs_sh[c] = 32'd0; m_shape_sh[c] = 0; m_amp_sh[c] = 256;
      m_ftw[c]    = 32'd0; m_pofs[c]    = 32'd0; m_shape[c]    = 0; m_amp[c]    = 256;
      m_acc[c]    = 32'd0;
    end
    pipe.delete();
    e_odac  = 16'h8080;
    e_valid = 1'b0;
    e_wrap  = 2'b00;
  endtask

  // One clock: advance the model with the inputs present at the edge, then check.
  task automatic tick();
    samp_t       s, o;
    logic [32:0] sum;
    @(posedge iclk);
    if (isample_en) begin
      for (int c = 0; c < NCH; c++) begin
        sum = {1'b0, m_acc[c]} + {1'b0, m_ftw[c]};
        m_acc[c] = sum[31:0];
        s.wrap[c] = sum[32];
        s.code[c*8 +: 8] = code_of(m_acc[c] + m_pofs[c], m_shape[c], m_amp[c]);
      end
      pipe.push_back(s);
      if (pipe.size() == 3) begin
        o = pipe.pop_front();
        e_odac  = o.code;
        e_wrap  = o.wrap;
        e_valid = 1'b1;
      end else begin
        e_valid = 1'b0;
      end
    end else begin
      e_valid = 1'b0;
    end
    if (iupdate) begin
      for (int c = 0; c < NCH; c++) begin
        m_ftw[c] = m_ftw_sh[c]; m_pofs[c] = m_pofs_sh[c];
        m_shape[c] = m_shape_sh[c]; m_amp[c] = m_amp_sh[c];
      end
    end else if (iwr_valid && int'(iwr_ch) < NCH) begin
      case (iwr_addr)
        2'd0: m_ftw_sh[iwr_ch]   = iwr_data;
        2'd1: m_pofs_sh[iwr_ch]  = iwr_data;
        2'd2: m_shape_sh[iwr_ch] = int'(iwr_data[1:0]);
        default: m_amp_sh[iwr_ch] = int'(iwr_data[8:0]);
      endcase
    end
    #1;
    check_val("ovalid", ovalid, e_valid);
    check_val("odac", odac, e_odac);
    check_val("owrap", owrap, e_wrap);
    check_val("owr_ready", owr_ready, !iupdate);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input int ch, input int addr, input logic [31:0] data);
    iwr_valid = 1'b1;
    iwr_ch    = 1'(ch);
    iwr_addr  = 2'(addr);
    iwr_data  = data;
    tick();
    iwr_valid = 1'b0;
  endtask

  task automatic commit();
    iupdate = 1'b1;
    tick();
    iupdate = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_odac"}, odac, 16'h8080);
    check_val({tag, "_ovalid"}, ovalid, 1'b0);
    check_val({tag, "_owrap"}, owrap, 2'b00);
    check_val({tag, "_ready"}, owr_ready, 1'b1);
  endtask

  task automatic do_reset();
    irst = 1'b1;
    #1;
    model_reset();
    check_reset_state("rst_async");
    @(posedge iclk);
    #1;
    check_reset_state("rst_hold");
    @(negedge iclk);
    irst = 1'b0;
  endtask

  initial begin
    irst = 1'b1; isample_en = 1'b0; iwr_valid = 1'b0; iwr_ch = 1'b0;
    iwr_addr = 2'd0; iwr_data = 32'd0; iupdate = 1'b0;
    model_reset();
    #2;
    check_reset_state("reset");
    @(posedge iclk);
    @(negedge iclk);
    irst = 1'b0;
    isample_en = 1'b1;
    run(3);
    check_val("fill_valid", ovalid, 1'b1);
    check_val("fill_odac", odac, 16'h8080);

    // Square on ch0, then the same on ch1 half a period ahead
    wr(0, 0, 32'h4000_0000);
    wr(0, 2, 32'd1);
    commit();
    run(12);
    wr(1, 0, 32'h4000_0000);
    wr(1, 2, 32'd1);
    wr(1, 1, 32'h8000_0000);
    commit();
    run(12);

    // Half amplitude square, then unity sawtooth ramp
    wr(0, 3, 32'd128);
    commit();
    run(8);
    wr(0, 2, 32'd3);
    wr(0, 0, 32'h0100_0000);
    wr(0, 3, 32'd256);
    commit();
    run(260);

    // Write and commit in the same cycle: write refused, accepted next cycle
    iwr_valid = 1'b1; iwr_ch = 1'b0; iwr_addr = 2'd0; iwr_data = 32'h0200_0000;
    iupdate = 1'b1;
    tick();
    iupdate = 1'b0;
    tick();
    iwr_valid = 1'b0;
    run(6);
    commit();
    run(6);

    // Hold mid-ramp
    isample_en = 1'b0;
    run(10);
    isample_en = 1'b1;
    run(6);

    // Reset in the middle of operation
    do_reset();
    run(5);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      isample_en = ($urandom_range(3) != 0);
      r = $urandom_range(15);
      if (r < 5) begin
        iwr_valid = 1'b1;
        iwr_ch    = 1'($urandom_range(1));
        iwr_addr  = 2'($urandom_range(3));
        iwr_data  = $urandom;
        if (iwr_addr == 2'd0 && $urandom_range(1) == 1) iwr_data = iwr_data >> 6;
      end else begin
        iwr_valid = 1'b0;
      end
      iupdate = (r >= 14);
      tick();
      if (i == 700) do_reset();
    end
    iwr_valid = 1'b0;
    iupdate = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
